// File: rtl/ray_bounce_ctrl.sv
// Single-ray bounce sequencer: accepts a camera ray, issues it to the tracer,
// folds reflector returns back into the next issue, and emits one pixel per ray.
// Optional feature: define RAY_EARLY_TERM_EN to stop bouncing once every
// component of the returned colour has an exponent below TERM_EXP.
module ray_bounce_ctrl #(
  parameter int unsigned MAX_BOUNCES = 4,
  parameter logic [6:0]  TERM_EXP    = 7'd55
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_valid,
  output logic          cam_ready,
  input  logic [71:0]   cam_origin,
  input  logic [71:0]   cam_dir,
  input  logic [10:0]   cam_hcount,
  input  logic [9:0]    cam_vcount,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [71:0]   trace_origin,
  output logic [71:0]   trace_dir,
  output logic [71:0]   trace_color,
  output logic [71:0]   trace_income_light,
  input  logic          trace_miss,
  input  logic          reflect_done,
  input  logic [71:0]   new_origin,
  input  logic [71:0]   new_dir,
  input  logic [71:0]   new_color,
  input  logic [71:0]   new_income_light,
  output logic          pixel_valid,
  input  logic          pixel_ready,
  output logic [71:0]   pixel_color,
  output logic [10:0]   pixel_hcount,
  output logic [9:0]    pixel_vcount,
  output logic [3:0]    pixel_bounces
);

  localparam int unsigned VEC_W = 72;
  localparam int unsigned H_W   = 11;
  localparam int unsigned V_W   = 10;
  localparam int unsigned B_W   = 4;
  localparam logic [VEC_W-1:0] WHITE = {3{24'h3f0000}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_e;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] origin_q, origin_d;
  logic [VEC_W-1:0] dir_q, dir_d;
  logic [VEC_W-1:0] color_q, color_d;
  logic [VEC_W-1:0] light_q, light_d;
  logic [H_W-1:0]   hcount_q, hcount_d;
  logic [V_W-1:0]   vcount_q, vcount_d;
  logic [B_W-1:0]   bounces_q, bounces_d;
  logic             cam_ready_q, cam_ready_d;
  logic             trace_valid_q, trace_valid_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [B_W-1:0]   bounce_inc_c;
  logic             early_term_c;

  // Early-termination decision on the returned colour exponents
`ifdef RAY_EARLY_TERM_EN
  assign early_term_c = (new_color[22:16] < TERM_EXP) &&
                        (new_color[46:40] < TERM_EXP) &&
                        (new_color[70:64] < TERM_EXP);
`else
  // Constant zero; TERM_EXP is only referenced so the parameter is not dangling
  assign early_term_c = 1'b0 & (^TERM_EXP);
`endif

  assign bounce_inc_c = bounces_q + B_W'(1);

  // Next-state, datapath loads and registered output strobes
  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    dir_d     = dir_q;
    color_d   = color_q;
    light_d   = light_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    bounces_d = bounces_q;
    case (state_q)
      IDLE: begin
        if (cam_valid && cam_ready_q) begin
          origin_d  = cam_origin;
          dir_d     = cam_dir;
          hcount_d  = cam_hcount;
          vcount_d  = cam_vcount;
          color_d   = WHITE;
          light_d   = '0;
          bounces_d = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (trace_ready) state_d = WAIT;
      end
      WAIT: begin
        if (trace_miss) begin
          state_d = OUTPUT;
        end else if (reflect_done) begin
          origin_d  = new_origin;
          dir_d     = new_dir;
          color_d   = new_color;
          light_d   = new_income_light;
          bounces_d = bounce_inc_c;
          if ((bounce_inc_c >= B_W'(MAX_BOUNCES)) || early_term_c) state_d = OUTPUT;
          else                                                        state_d = ISSUE;
        end
      end
      OUTPUT: begin
        if (pixel_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cam_ready_d   = (state_d == IDLE);
    trace_valid_d = (state_d == ISSUE);
    pixel_valid_d = (state_d == OUTPUT);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      origin_q      <= '0;
      dir_q         <= '0;
      color_q       <= '0;
      light_q       <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      bounces_q     <= '0;
      cam_ready_q   <= 1'b0;
      trace_valid_q <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      origin_q      <= origin_d;
      dir_q         <= dir_d;
      color_q       <= color_d;
      light_q       <= light_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      bounces_q     <= bounces_d;
      cam_ready_q   <= cam_ready_d;
      trace_valid_q <= trace_valid_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign cam_ready          = cam_ready_q;
  assign trace_valid        = trace_valid_q;
  assign trace_origin       = origin_q;
  assign trace_dir          = dir_q;
  assign trace_color        = color_q;
  assign trace_income_light = light_q;
  assign pixel_valid        = pixel_valid_q;
  assign pixel_color        = light_q;
  assign pixel_hcount       = hcount_q;
  assign pixel_vcount       = vcount_q;
  assign pixel_bounces      = bounces_q;

endmodule

// File: tb/tb_ray_bounce_ctrl.sv
// Directed bench for ray_bounce_ctrl (MAX_BOUNCES=4); follows RAY_EARLY_TERM_EN.
module tb_ray_bounce_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_valid, cam_ready;
  logic [71:0] cam_origin, cam_dir;
  logic [10:0] cam_hcount;
  logic [9:0]  cam_vcount;
  logic        trace_valid, trace_ready;
  logic [71:0] trace_origin, trace_dir, trace_color, trace_income_light;
  logic        trace_miss, reflect_done;
  logic [71:0] new_origin, new_dir, new_color, new_income_light;
  logic        pixel_valid, pixel_ready;
  logic [71:0] pixel_color;
  logic [10:0] pixel_hcount;
  logic [9:0]  pixel_vcount;
  logic [3:0]  pixel_bounces;

  int n_checks = 0;
  int n_pass   = 0;

  ray_bounce_ctrl #(.MAX_BOUNCES(4), .TERM_EXP(7'd55)) dut (
    .clk(clk), .rst(rst),
    .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_origin(cam_origin),
    .cam_dir(cam_dir), .cam_hcount(cam_hcount), .cam_vcount(cam_vcount),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_origin(trace_origin),
    .trace_dir(trace_dir), .trace_color(trace_color), .trace_income_light(trace_income_light),
    .trace_miss(trace_miss), .reflect_done(reflect_done), .new_origin(new_origin),
    .new_dir(new_dir), .new_color(new_color), .new_income_light(new_income_light),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_color(pixel_color),
    .pixel_hcount(pixel_hcount), .pixel_vcount(pixel_vcount), .pixel_bounces(pixel_bounces)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a camera ray for one accepting edge (DUT must be idle)
  task automatic accept_ray(input logic [10:0] h, input logic [9:0] v, input logic [71:0] org);
    cam_valid  = 1'b1;
    cam_hcount = h;
    cam_vcount = v;
    cam_origin = org;
    cam_dir    = {3{24'h400000}};
    tick();
    cam_valid  = 1'b0;
  endtask

  // Tracer accepts the issued ray; DUT moves to WAIT
  task automatic trace_hs();
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
  endtask

  task automatic reflect(input logic [71:0] col, input logic [71:0] lgt, input logic miss);
    reflect_done     = 1'b1;
    trace_miss       = miss;
    new_color        = col;
    new_income_light = lgt;
    new_origin       = {3{24'h410000}};
    new_dir          = {3{24'h420000}};
    tick();
    reflect_done = 1'b0;
    trace_miss   = 1'b0;
  endtask

  task automatic pixel_hs();
    pixel_ready = 1'b1;
    tick();
    pixel_ready = 1'b0;
  endtask

  initial begin
    logic [71:0] l1, l2;
    rst = 1'b1;
    cam_valid = 0; cam_origin = '0; cam_dir = '0; cam_hcount = '0; cam_vcount = '0;
    trace_ready = 0; trace_miss = 0; reflect_done = 0;
    new_origin = '0; new_dir = '0; new_color = '0; new_income_light = '0;
    pixel_ready = 0;
    tick();
    tick();
    check("rst_cam_ready", 72'(cam_ready), 72'd0);
    check("rst_trace_valid", 72'(trace_valid), 72'd0);
    check("rst_pixel_valid", 72'(pixel_valid), 72'd0);
    check("rst_pixel_color", pixel_color, 72'd0);
    rst = 1'b0;
    tick();
    check("post_rst_cam_ready", 72'(cam_ready), 72'd1);

    // Full-depth ray: four reflections, forced termination
    accept_ray(11'd5, 10'd7, {24'h3f0000, 24'h400000, 24'h410000});
    check("A_trace_valid", 72'(trace_valid), 72'd1);
    check("A_trace_color", trace_color, {3{24'h3f0000}});
    check("A_trace_light", trace_income_light, 72'd0);
    check("A_trace_origin", trace_origin, {24'h3f0000, 24'h400000, 24'h410000});
    check("A_cam_ready_busy", 72'(cam_ready), 72'd0);
    tick();
    check("A_issue_hold", 72'(trace_valid), 72'd1);
    for (int b = 1; b <= 4; b++) begin
      trace_hs();
      check("A_wait_no_valid", 72'(trace_valid), 72'd0);
      reflect({3{24'h3e0000}}, {3{24'h3d0000}}, 1'b0);
      if (b < 4) begin
        check("A_reissue", 72'(trace_valid), 72'd1);
        check("A_reissue_color", trace_color, {3{24'h3e0000}});
        check("A_reissue_dir", trace_dir, {3{24'h420000}});
      end
    end
    check("A_pixel_valid", 72'(pixel_valid), 72'd1);
    check("A_pixel_color", pixel_color, {3{24'h3d0000}});
    check("A_pixel_bounces", 72'(pixel_bounces), 72'd4);
    check("A_pixel_h", 72'(pixel_hcount), 72'd5);
    check("A_pixel_v", 72'(pixel_vcount), 72'd7);
    // Backpressure on the pixel port; stray pulses must be ignored
    for (int i = 0; i < 10; i++) begin
      reflect_done = (i == 3);
      trace_miss   = (i == 5);
      new_income_light = {3{24'h111111}};
      tick();
      check("A_hold_valid", 72'(pixel_valid), 72'd1);
      check("A_hold_color", pixel_color, {3{24'h3d0000}});
      check("A_hold_cam_ready", 72'(cam_ready), 72'd0);
    end
    reflect_done = 0; trace_miss = 0;
    pixel_hs();
    check("A_after_px_cam_ready", 72'(cam_ready), 72'd1);
    check("A_after_px_valid", 72'(pixel_valid), 72'd0);
    // Pulses in IDLE do nothing
    reflect({3{24'h300000}}, {3{24'h222222}}, 1'b1);
    check("idle_pulse_cam_ready", 72'(cam_ready), 72'd1);
    check("idle_pulse_pixel", 72'(pixel_valid), 72'd0);

    // Two bounces then a miss coinciding with a reflection: miss wins
    l1 = {24'h3c0000, 24'h3c1000, 24'h3c2000};
    l2 = {24'h3b0000, 24'h3b1000, 24'h3b2000};
    accept_ray(11'd9, 10'd3, {3{24'h3f8000}});
    trace_hs();
    reflect({3{24'h3e0000}}, l1, 1'b0);
    trace_hs();
    reflect({3{24'h3e0000}}, l2, 1'b0);
    trace_hs();
    reflect({3{24'h3e0000}}, {3{24'h3a0000}}, 1'b1);
    check("B_pixel_valid", 72'(pixel_valid), 72'd1);
    check("B_trace_valid", 72'(trace_valid), 72'd0);
    check("B_pixel_color", pixel_color, l2);
    check("B_pixel_bounces", 72'(pixel_bounces), 72'd2);
    check("B_pixel_h", 72'(pixel_hcount), 72'd9);
    pixel_hs();

    // Immediate miss: no bounces, zero light
    accept_ray(11'd1, 10'd2, {3{24'h3f0000}});
    trace_hs();
    trace_miss = 1'b1;
    tick();
    trace_miss = 1'b0;
    check("C_pixel_valid", 72'(pixel_valid), 72'd1);
    check("C_pixel_bounces", 72'(pixel_bounces), 72'd0);
    check("C_pixel_color", pixel_color, 72'd0);
    pixel_hs();

    // Dim returned colour on bounce 1
    accept_ray(11'd4, 10'd4, {3{24'h3f0000}});
    trace_hs();
    reflect({3{24'h300000}}, {3{24'h380000}}, 1'b0);
`ifdef RAY_EARLY_TERM_EN
    check("D_early_pixel", 72'(pixel_valid), 72'd1);
    check("D_early_bounces", 72'(pixel_bounces), 72'd1);
    check("D_early_color", pixel_color, {3{24'h380000}});
`else
    check("D_reissue", 72'(trace_valid), 72'd1);
    check("D_no_pixel", 72'(pixel_valid), 72'd0);
    trace_hs();
    trace_miss = 1'b1;
    tick();
    trace_miss = 1'b0;
    check("D_miss_bounces", 72'(pixel_bounces), 72'd1);
`endif
    pixel_hs();

    // Reset while waiting on the tracer, then a stale return
    accept_ray(11'd6, 10'd6, {3{24'h3f0000}});
    trace_hs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reflect({3{24'h3e0000}}, {3{24'h3d0000}}, 1'b0);
    check("E_no_trace", 72'(trace_valid), 72'd0);
    check("E_no_pixel", 72'(pixel_valid), 72'd0);
    check("E_cam_ready", 72'(cam_ready), 72'd1);
    tick();
    check("E_still_no_pixel", 72'(pixel_valid), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
